rv32_dmem_responder: RTL and testbench

//  Data-memory responder for the RV32I datapath: the memory-side end of its load/store port.

---
 rtl/rv32_dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_rv32_dmem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32_dmem_responder.sv
// rv32_dmem_responder: memory-side end of the RV32I load/store port with a programmable access wait.
// Build option DMEM_MISALIGN_CHECK_EN: misaligned half/word accesses fault instead of being masked.
module rv32_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          bad_funct3;
  logic          misaligned;
  logic          acc_err;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_rep;
  logic [31:0]   rd_word;
  logic [15:0]   rd_lane;
  logic [31:0]   ld_data;
  logic          mem_we;

  assign word_idx     = addr_q[AW+1:2];
  assign out_of_range = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
  // 011/110/111 are not RV32I accesses; unsigned variants make no sense for stores
  assign bad_funct3   = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11) ||
                        (we_q && funct3_q[2]);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
  assign lane       = addr_q[1:0];
`else
  assign misaligned = 1'b0;
  always_comb begin
    lane = addr_q[1:0];
    case (funct3_q[1:0])
      2'b01:   lane[0] = 1'b0;
      2'b10:   lane    = 2'b00;
      default: ;
    endcase
  end
`endif

  assign acc_err = out_of_range || bad_funct3 || misaligned;

  always_comb begin
    byte_en   = 4'b1111;
    wdata_rep = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_word = out_of_range ? 32'h0 : mem[word_idx];
  assign rd_lane = 16'(rd_word >> {lane, 3'b000});

  always_comb begin
    ld_data = rd_word;
    case (funct3_q)
      3'b000:  ld_data = {{24{rd_lane[7]}}, rd_lane[7:0]};
      3'b001:  ld_data = {{16{rd_lane[15]}}, rd_lane};
      3'b100:  ld_data = {24'h0, rd_lane[7:0]};
      3'b101:  ld_data = {16'h0, rd_lane};
      default: ;
    endcase
  end

  // array has no reset: contents survive reset_n
  assign mem_we = (state_q == S_ACCESS) && we_q && !acc_err;

  always_ff @(posedge clock_i) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      funct3_q    <= 3'b000;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            funct3_q    <= req_funct3_i;
            wdata_q     <= req_wdata_i;
            req_ready_q <= 1'b0;
            cnt_q       <= 4'(LATENCY);
            state_q     <= (LATENCY == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          rsp_err_q   <= acc_err;
          rsp_rdata_q <= (acc_err || we_q) ? 32'h0 : ld_data;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Bench for rv32_dmem_responder: vector table plus response scoreboard, with hand-written
// sequences for back-pressure and reset during the wait phase.
module tb_rv32_dmem_responder;
  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam logic [31:0] LW12_DATA = 32'h0;
  localparam logic        LW12_ERR  = 1'b1;
  localparam logic        SH13_ERR  = 1'b1;
  localparam logic [31:0] W10_FINAL = 32'hDEADAAEF;
`else
  localparam logic [31:0] LW12_DATA = 32'hDEADAAEF;
  localparam logic        LW12_ERR  = 1'b0;
  localparam logic        SH13_ERR  = 1'b0;
  localparam logic [31:0] W10_FINAL = 32'hFFFFAAEF;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 clock = ~clock;

  rv32_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clock_i(clock), .reset_n_i(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_funct3_i(req_funct3), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic we, logic [31:0] a, logic [2:0] f, logic [31:0] wd,
                              logic [31:0] er, logic ee);
    vec_t v;
    v.we = we; v.addr = a; v.f3 = f; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_we = v.we; req_addr = v.addr; req_funct3 = v.f3; req_wdata = v.wdata;
    req_valid = 1'b1;
  endtask

  // Issue one request and wait for its response; leaves the response pending.
  task automatic issue(input vec_t v, input string name, output bit got);
    rsp_t e;
    int   n;
    @(negedge clock);
    chk({name, " req_ready idle"}, 32'(req_ready), 32'd1);
    drive(v);
    e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb.push_back(e);
    @(posedge clock);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rsp_valid && n < 40);
    e = sb.pop_front();
    got = rsp_valid;
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s timeout: no rsp_valid after %0d cycles, expected %0d", name, n, LAT + 2);
    end else begin
      chk({name, " latency"}, 32'(n), 32'(LAT + 2));
      chk({name, " rdata"}, rsp_rdata, e.rdata);
      chk({name, " err"}, 32'(rsp_err), 32'(e.err));
    end
  endtask

  task automatic handshake(input string name);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    @(negedge clock);
    chk({name, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic run(input vec_t v, input string name);
    bit got;
    issue(v, name, got);
    if (got) handshake(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    bit got;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_funct3 = 3'b0; req_wdata = 32'h0; rsp_ready = 1'b0;

    vecs.push_back(mk(1'b1, 32'h10,       3'b010, 32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h10,       3'b010, 32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b0, 32'h13,       3'b000, 32'h0,        32'hFFFFFFDE, 1'b0));
    vecs.push_back(mk(1'b0, 32'h13,       3'b100, 32'h0,        32'h000000DE, 1'b0));
    vecs.push_back(mk(1'b0, 32'h10,       3'b001, 32'h0,        32'hFFFFBEEF, 1'b0));
    vecs.push_back(mk(1'b0, 32'h12,       3'b101, 32'h0,        32'h0000DEAD, 1'b0));
    vecs.push_back(mk(1'b1, 32'h11,       3'b000, 32'h000000AA, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h10,       3'b010, 32'h0,        32'hDEADAAEF, 1'b0));
    vecs.push_back(mk(1'b0, 32'h11,       3'b000, 32'h0,        32'hFFFFFFAA, 1'b0));
    vecs.push_back(mk(1'b0, 32'(4*DEPTH), 3'b010, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 32'h10,       3'b100, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 32'h10,       3'b110, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 32'h10,       3'b011, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 32'h10,       3'b010, 32'h0,        32'hDEADAAEF, 1'b0));
    vecs.push_back(mk(1'b0, 32'h80000010, 3'b010, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 32'(4*DEPTH-4), 3'b010, 32'h01234567, 32'h0,      1'b0));
    vecs.push_back(mk(1'b0, 32'(4*DEPTH-4), 3'b010, 32'h0,      32'h01234567, 1'b0));
    vecs.push_back(mk(1'b0, 32'h12,       3'b010, 32'h0,        LW12_DATA,    LW12_ERR));
    vecs.push_back(mk(1'b1, 32'h14,       3'b010, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 32'h16,       3'b001, 32'h12345678, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h14,       3'b010, 32'h0,        32'h56780000, 1'b0));
    vecs.push_back(mk(1'b0, 32'h16,       3'b001, 32'h0,        32'h00005678, 1'b0));
    vecs.push_back(mk(1'b0, 32'h14,       3'b101, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 32'h13,       3'b001, 32'h0000FFFF, 32'h0,        SH13_ERR));
    vecs.push_back(mk(1'b0, 32'h10,       3'b010, 32'h0,        W10_FINAL,    1'b0));

    repeat (2) @(negedge clock);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err",   32'(rsp_err), 32'd0);
    reset_n = 1'b1;

    // rsp_ready while idle must not produce a response
    rsp_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle rsp_ready valid", 32'(rsp_valid), 32'd0);
    chk("idle rsp_ready ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;

    foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

    // back-pressure: response held, competing store ignored
    issue(mk(1'b0, 32'h10, 3'b010, 32'h0, W10_FINAL, 1'b0), "hold", got);
    if (got) begin
      for (int k = 0; k < 5; k++) begin
        drive(mk(1'b1, 32'h10, 3'b010, 32'h0, 32'h0, 1'b0));
        @(negedge clock);
        chk($sformatf("hold%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
        chk($sformatf("hold%0d rdata", k), rsp_rdata, W10_FINAL);
        chk($sformatf("hold%0d req_ready", k), 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      handshake("hold");
    end
    run(mk(1'b0, 32'h10, 3'b010, 32'h0, W10_FINAL, 1'b0), "after hold");

    // reset during the wait phase aborts the store
    run(mk(1'b1, 32'h20, 3'b010, 32'h11111111, 32'h0, 1'b0), "pre-reset store");
    @(negedge clock);
    drive(mk(1'b1, 32'h20, 3'b010, 32'h22222222, 32'h0, 1'b0));
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst wait req_ready", 32'(req_ready), 32'd1);
    chk("rst wait rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst wait rsp_rdata", rsp_rdata, 32'h0);
    chk("rst wait rsp_err",   32'(rsp_err), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (LAT + 3) @(negedge clock);
    chk("rst no stray rsp", 32'(rsp_valid), 32'd0);
    run(mk(1'b0, 32'h20, 3'b010, 32'h0, 32'h11111111, 1'b0), "post-reset load");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
